traffic_light_ctrl: RTL and testbench
=====================================

// Module: traffic_light_ctrl
// PURPOSE
//  Highway/north-road intersection controller; consumes the TS/TLH/TLN expiry flags of Timer
//  and drives both roads' lamps. Top level wires Timer's reset as (reset | st), so this block
//  restarts the timer on every phase change. Also handles north car sensor and a flash/fault mode.
// PARAMETERS
//  FLASH_HALF  25  cycles per blink half-period in flash mode (>=1)
//  SYNC_STAGES 2   synchronizer depth on car_n and flash inputs (>=2)
// PORTS
//  clk      in  1  single clock, rising edge
//  reset    in  1  synchronous, active-high
//  TS       in  1  short-interval expired (Timer)
//  TLH      in  1  highway long-interval expired (Timer)
//  TLN      in  1  north long-interval expired (Timer)
//  car_n    in  1  car waiting on north road, asynchronous
//  flash    in  1  fault/night request, asynchronous, level
//  st       out 1  timer restart pulse, registered
//  hwy      out 3  highway lamps {R,Y,G}, one-hot or 000
//  nth      out 3  north lamps {R,Y,G}, one-hot or 000
//  state_o  out 3  current state code, debug
// BEHAVIOUR
//  - Timer contract: an expiry flag is high in every cycle >= N_VALUE cycles after Timer's
//    reset was last high. Flags stay high until the next restart.
//  - car_n and flash pass through SYNC_STAGES flops before use. Sync flops reset to 0.
//  - All outputs registered (Moore). Reset values: state HG, st=1, hwy=001 (G), nth=100 (R),
//    blink counter 0. The st=1 on reset keeps Timer cleared through the first cycle.
//  - States and lamp values:
//      HG: hwy=G, nth=R
//      HY: hwy=Y, nth=R
//      NG: hwy=R, nth=G
//      NY: hwy=R, nth=Y
//      FL: hwy=Y/000 blinking, nth=R/000 blinking, in phase
//  - Transitions are evaluated on each edge in priority order, flash first:
//      any state, flash_s=1 -> FL
//      HG -> HY when TLH & car_s
//      HY -> NG when TS
//      NG -> NY when TLN | ~car_s
//      NY -> HG when TS
//      FL -> HY when flash_s=0; the highway yellow phase is always run before a green
//  - st=1 for exactly the first cycle of every newly entered state, and 0 otherwise.
//    Staying in FL does not pulse st.
//  - Flash blink: the counter runs 0..FLASH_HALF-1 only in FL. The lamps toggle on wrap.
//    The lamps are on in the first half-period after FL entry. The counter clears on exiting FL.
//  - Flash asserted while st is high: FL is still entered next edge; st pulses again.
//  - Simultaneous expiry flags: only the flag named for the current state matters; others are ignored.
//  - Reset mid-phase, including FL: next cycle equals the reset values above; sync flops cleared.
//  - Never drive green or yellow on both roads at once.
//    Never change directly G->R; yellow is always interposed except on FL entry.
// STRUCTURE
//  - Shared include TrafficDefs.vh holds:
//      state codes HG=0, HY=1, NG=2, NY=3, FL=4
//      lamp constants L_RED=3'b100, L_YEL=3'b010, L_GRN=3'b001, L_OFF=3'b000
//  - One sub-module: blink_gen (FLASH_HALF counter + toggle, enable=in_FL, clear on exit).
//  - Synchronizers inline; next-state/output logic in traffic_light_ctrl.
//  - Bench instantiates Timer #(TS_VALUE=2, TLH_VALUE=8, TLN_VALUE=5) with reset|st.
// TESTING
//  1. Reset held 2 cycles -> hwy=001, nth=100, st=1, state_o=0 on each cycle of reset.
//  2. car_n=1 from reset -> full cycle HG->HY->NG->NY->HG.
//     HG lasts 9 cycles, HY 3, NG 6, NY 3; st=1 once at each entry.
//  3. car_n=0 forever -> stays HG indefinitely with TLH high; st stays 0 after cycle 0.
//  4. car_n drops mid-NG (2 cycles in) -> NY entered SYNC_STAGES+1 cycles later,
//     before TLN expires.
//  5. flash=1 during NG -> FL within SYNC_STAGES+1 cycles. hwy toggles 010/000 and nth 100/000
//     every 25 cycles. Release -> HY with st=1, then NG after TS.
//  6. reset asserted in FL mid-blink -> next cycle HG reset values, blink counter 0.
//  All scenarios: assert lamp-safety invariant and one-hot-or-zero lamps every cycle.

Source files
------------

// File: rtl/traffic_light_ctrl_pkg.sv
// Shared state codes, lamp encodings and lamp lookup
// for the highway/north intersection controller.
package traffic_light_ctrl_pkg;

    typedef enum logic [2:0] {
        HG = 3'd0,
        HY = 3'd1,
        NG = 3'd2,
        NY = 3'd3,
        FL = 3'd4
    } state_e;

    localparam logic [2:0] L_RED = 3'b100;
    localparam logic [2:0] L_YEL = 3'b010;
    localparam logic [2:0] L_GRN = 3'b001;
    localparam logic [2:0] L_OFF = 3'b000;

    // {hwy, nth} lamps for a state; on selects the blink phase in FL
    function automatic logic [5:0] lamp_pair(
        input state_e s,
        input logic   on
    );
        logic [5:0] r;
        r = {L_GRN, L_RED};
        case (s)
            HG:      r = {L_GRN, L_RED};
            HY:      r = {L_YEL, L_RED};
            NG:      r = {L_RED, L_GRN};
            NY:      r = {L_RED, L_YEL};
            FL:      r = on ? {L_YEL, L_RED} : {L_OFF, L_OFF};
            default: r = {L_GRN, L_RED};
        endcase
        return r;
    endfunction

endpackage

// File: rtl/traffic_light_ctrl_blink.sv
// Flash-mode blink generator: half-period counter
// with a phase toggle on every wrap.
module blink_gen #(
    parameter int unsigned FLASH_HALF = 25
) (
    input  logic clk,
    input  logic reset,
    input  logic en_i,
    input  logic clr_i,
    output logic on_next_o
);

    localparam int unsigned CW =
        (FLASH_HALF > 1) ? $clog2(FLASH_HALF) : 1;
    localparam logic [CW-1:0] LAST = CW'(FLASH_HALF - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          on_q, on_d;

    // Count while flashing; restart in the lit phase otherwise
    always_comb begin
        cnt_d = cnt_q;
        on_d  = on_q;
        if (clr_i) begin
            cnt_d = '0;
            on_d  = 1'b1;
        end else if (en_i) begin
            if (cnt_q == LAST) begin
                cnt_d = '0;
                on_d  = ~on_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    // Counter and phase registers
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
            on_q  <= 1'b1;
        end else begin
            cnt_q <= cnt_d;
            on_q  <= on_d;
        end
    end

    assign on_next_o = on_d;

endmodule

// File: rtl/traffic_light_ctrl.sv
// Highway/north intersection controller: phase FSM,
// input synchronizers and registered lamp outputs.
module traffic_light_ctrl
    import traffic_light_ctrl_pkg::*;
#(
    parameter int unsigned FLASH_HALF  = 25,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       TS,
    input  logic       TLH,
    input  logic       TLN,
    input  logic       car_n,
    input  logic       flash,
    output logic       st,
    output logic [2:0] hwy,
    output logic [2:0] nth,
    output logic [2:0] state_o
);

    logic [SYNC_STAGES-1:0] car_sync_q;
    logic [SYNC_STAGES-1:0] flash_sync_q;
    logic                   car_s;
    logic                   flash_s;

    state_e     state_q, state_d;
    logic       st_q, st_d;
    logic [2:0] hwy_q, hwy_d;
    logic [2:0] nth_q, nth_d;
    logic       blink_on_d;
    logic       in_fl;
    logic       leave_fl;

    // Bring the asynchronous sensor and flash request into clk
    always_ff @(posedge clk) begin
        if (reset) begin
            car_sync_q   <= '0;
            flash_sync_q <= '0;
        end else begin
            car_sync_q   <= {car_sync_q[SYNC_STAGES-2:0], car_n};
            flash_sync_q <= {flash_sync_q[SYNC_STAGES-2:0], flash};
        end
    end

    assign car_s   = car_sync_q[SYNC_STAGES-1];
    assign flash_s = flash_sync_q[SYNC_STAGES-1];

    assign in_fl    = (state_q == FL);
    assign leave_fl = (state_d != FL);

    blink_gen #(
        .FLASH_HALF (FLASH_HALF)
    ) u_blink (
        .clk       (clk),
        .reset     (reset),
        .en_i      (in_fl),
        .clr_i     (leave_fl),
        .on_next_o (blink_on_d)
    );

    // Next phase; flash overrides, each phase waits on its own flag
    always_comb begin
        state_d = state_q;
        if (flash_s) begin
            state_d = FL;
        end else begin
            unique case (state_q)
                HG: if (TLH && car_s)  state_d = HY;
                HY: if (TS)            state_d = NG;
                NG: if (TLN || !car_s) state_d = NY;
                NY: if (TS)            state_d = HG;
                FL:                    state_d = HY;
                default:               state_d = HG;
            endcase
        end
    end

    // Moore outputs computed from the phase about to be entered
    always_comb begin
        st_d         = (state_d != state_q);
        {hwy_d, nth_d} = lamp_pair(state_d, blink_on_d);
    end

    // Phase and output registers; reset holds the timer cleared
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= HG;
            st_q    <= 1'b1;
            hwy_q   <= L_GRN;
            nth_q   <= L_RED;
        end else begin
            state_q <= state_d;
            st_q    <= st_d;
            hwy_q   <= hwy_d;
            nth_q   <= nth_d;
        end
    end

    assign st      = st_q;
    assign hwy     = hwy_q;
    assign nth     = nth_q;
    assign state_o = state_q;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Self-checking bench: Timer model, phase/age reference
// model, directed scenarios then randomized stimulus.
module tb_traffic_light_ctrl;

    localparam int FH    = 25;
    localparam int SS    = 2;
    localparam int TS_V  = 2;
    localparam int TLH_V = 8;
    localparam int TLN_V = 5;

    localparam logic [2:0] RED = 3'b100;
    localparam logic [2:0] YEL = 3'b010;
    localparam logic [2:0] GRN = 3'b001;
    localparam logic [2:0] OFF = 3'b000;

    logic       clk = 1'b0;
    logic       reset;
    logic       car_n;
    logic       flash;
    logic       TS, TLH, TLN;
    logic       st;
    logic [2:0] hwy, nth, state_o;

    always #5 clk = ~clk;

    traffic_light_ctrl #(
        .FLASH_HALF  (FH),
        .SYNC_STAGES (SS)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .TS      (TS),
        .TLH     (TLH),
        .TLN     (TLN),
        .car_n   (car_n),
        .flash   (flash),
        .st      (st),
        .hwy     (hwy),
        .nth     (nth),
        .state_o (state_o)
    );

    // Timer: flag N is high once N cycles have passed since reset|st
    int unsigned tcnt = 0;
    logic        trst;
    assign trst = reset | st;
    always @(posedge clk) begin
        if (trst)            tcnt <= 0;
        else if (tcnt < 1000) tcnt <= tcnt + 1;
    end
    assign TS  = !trst && (tcnt >= TS_V - 1);
    assign TLH = !trst && (tcnt >= TLH_V - 1);
    assign TLN = !trst && (tcnt >= TLN_V - 1);

    // Reference model: current phase and cycles spent in it
    int m_ph  = 0;
    int m_age = 0;
    bit mc [SS];
    bit mf [SS];

    int n_chk  = 0;
    int n_pass = 0;
    int cyc_n  = 0;

    logic [2:0] prev_h = GRN;
    logic [2:0] prev_n = RED;
    logic       last_rst = 1'b1;

    task automatic check(
        input string       tag,
        input logic [31:0] got,
        input logic [31:0] exp
    );
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                      tag, got, exp, cyc_n);
    endtask

    function automatic logic [2:0] exp_h(input int ph, input int age);
        case (ph)
            0:       return GRN;
            1:       return YEL;
            2, 3:    return RED;
            default: return ((age / FH) % 2 == 0) ? YEL : OFF;
        endcase
    endfunction

    function automatic logic [2:0] exp_n(input int ph, input int age);
        case (ph)
            0, 1:    return RED;
            2:       return GRN;
            3:       return YEL;
            default: return ((age / FH) % 2 == 0) ? RED : OFF;
        endcase
    endfunction

    task automatic model_step();
        int nx;
        bit cs, fs;
        if (reset) begin
            m_ph  = 0;
            m_age = 0;
            for (int i = 0; i < SS; i++) begin
                mc[i] = 1'b0;
                mf[i] = 1'b0;
            end
            return;
        end
        cs = mc[SS-1];
        fs = mf[SS-1];
        nx = m_ph;
        if (fs) nx = 4;
        else begin
            case (m_ph)
                0: if (m_age >= TLH_V && cs)  nx = 1;
                1: if (m_age >= TS_V)         nx = 2;
                2: if (m_age >= TLN_V || !cs) nx = 3;
                3: if (m_age >= TS_V)         nx = 0;
                default:                      nx = 1;
            endcase
        end
        m_age = (nx == m_ph) ? m_age + 1 : 0;
        m_ph  = nx;
        for (int i = SS - 1; i > 0; i--) begin
            mc[i] = mc[i-1];
            mf[i] = mf[i-1];
        end
        mc[0] = car_n;
        mf[0] = flash;
    endtask

    // One clock: compare mid-cycle, advance model, step past edge
    task automatic cyc();
        @(negedge clk);
        check("state", {29'd0, state_o}, m_ph);
        check("st", {31'd0, st}, {31'd0, m_age == 0});
        check("hwy", {29'd0, hwy}, {29'd0, exp_h(m_ph, m_age)});
        check("nth", {29'd0, nth}, {29'd0, exp_n(m_ph, m_age)});
        check("safe", {31'd0, (hwy[1:0] != 2'b00) && (nth[1:0] != 2'b00)}, 0);
        check("onehot", {31'd0, $onehot0(hwy) && $onehot0(nth)}, 1);
        if (!last_rst && prev_h == GRN)
            check("h_g2r", {31'd0, hwy == RED}, 0);
        if (!last_rst && prev_n == GRN && state_o != 3'd4)
            check("n_g2r", {31'd0, nth == RED}, 0);
        prev_h   = hwy;
        prev_n   = nth;
        last_rst = reset;
        model_step();
        @(posedge clk);
        #1;
        cyc_n++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
    endtask

    initial begin
        int k;
        reset = 1'b1;
        car_n = 1'b1;
        flash = 1'b0;
        @(posedge clk);
        #1;

        // Reset held two cycles, then a full car-driven rotation
        cyc();
        cyc();
        reset = 1'b0;
        run(30);

        // No north traffic: highway stays green
        car_n = 1'b0;
        do_reset();
        run(40);
        check("hg_hold", {29'd0, state_o}, 0);

        // Car leaves two cycles into north green
        car_n = 1'b1;
        do_reset();
        k = 0;
        while (!(m_ph == 2 && m_age == 2) && k < 60) begin
            cyc();
            k++;
        end
        check("ng_reached", {29'd0, state_o}, 2);
        car_n = 1'b0;
        k = 0;
        while (state_o != 3'd3 && k < 20) begin
            cyc();
            k++;
        end
        check("ny_latency", k, SS + 1);
        run(10);

        // Flash during north green, blink, then release
        car_n = 1'b1;
        do_reset();
        k = 0;
        while (state_o != 3'd2 && k < 60) begin
            cyc();
            k++;
        end
        flash = 1'b1;
        k = 0;
        while (state_o != 3'd4 && k < 20) begin
            cyc();
            k++;
        end
        check("fl_latency", k, SS + 1);
        run(120);
        flash = 1'b0;
        k = 0;
        while (state_o != 3'd1 && k < 20) begin
            cyc();
            k++;
        end
        check("fl_exit", k, SS + 1);
        check("fl_exit_st", {31'd0, st}, 1);
        run(15);

        // Reset in the middle of a blink half-period
        flash = 1'b1;
        run(SS + 37);
        flash = 1'b0;
        do_reset();
        check("rst_state", {29'd0, state_o}, 0);
        check("rst_hwy", {29'd0, hwy}, {29'd0, GRN});
        run(10);

        // Randomized sensor, flash and reset activity
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 11) == 0) car_n = ~car_n;
            if ($urandom_range(0, 199) == 0) flash = ~flash;
            reset = ($urandom_range(0, 399) == 0);
            cyc();
        end
        reset = 1'b0;
        flash = 1'b0;
        run(20);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
